pc_fetch: RTL

- Program-counter and instruction-fetch stage of the 16-bit CPU.
- Sits directly downstream of the wordmux that chooses between the sequential path and a branch target.
  - That mux's o_val drives i_target.
  - Its select, qualified as a taken branch, drives i_redirect.
- Holds the PC, issues single-word requests to instruction memory with a req/ack handshake, and presents one fetched instruction at a time to decode, with stall backpressure.
- Decodes the HALT word.

---
 rtl/pc_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch
//  Purpose  : Program counter and instruction-fetch stage of the 16-bit CPU.
//             Holds the PC, issues single-word requests to instruction memory
//             over a req/ack handshake, and presents one fetched instruction
//             at a time to decode with stall backpressure. Fetch stops after
//             the HALT word has been accepted; a redirect restarts it.
//
//  Ports    : i_clk, i_rst          clock, synchronous active-high reset
//             i_target, i_redirect  branch target and load strobe
//             i_stall               decode not ready, hold presented slot
//             o_imem_req/o_imem_addr, i_imem_ack/i_imem_data  memory handshake
//             o_instr, o_instr_pc, o_instr_valid  presented instruction slot
//             o_halted              fetch stopped on HALT_WORD
//             o_fetch_count         accepted-fetch counter (optional)
//
//  Options  : PC_FETCH_COUNT_EN - when defined, adds o_fetch_count, a
//             saturating count of accepted fetches cleared only by reset.
//
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch #(
    parameter int                 WIDTH     = 16,
    parameter logic [0:WIDTH-1]   RESET_PC  = 16'h0000,
    parameter int                 ADDR_INC  = 1,
    parameter logic [0:WIDTH-1]   HALT_WORD = 16'hFFFF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [0:WIDTH-1]    i_target,
    input  logic                i_redirect,
    input  logic                i_stall,
    output logic                o_imem_req,
    output logic [0:WIDTH-1]    o_imem_addr,
    input  logic                i_imem_ack,
    input  logic [0:WIDTH-1]    i_imem_data,
    output logic [0:WIDTH-1]    o_instr,
    output logic [0:WIDTH-1]    o_instr_pc,
    output logic                o_instr_valid,
    output logic                o_halted
`ifdef PC_FETCH_COUNT_EN
    ,
    output logic [0:WIDTH-1]    o_fetch_count
`endif
);

    localparam logic [0:WIDTH-1] c_inc = WIDTH'(ADDR_INC);

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             r_state;
    logic [0:WIDTH-1]   r_pc;
    logic [0:WIDTH-1]   r_instr;
    logic [0:WIDTH-1]   r_instr_pc;
    logic               r_instr_valid;

    logic               w_req;
    logic               w_accept;
    logic               w_consume;

    // A request is only raised when the slot is free or is being drained this
    // cycle, so an accepted word never overwrites an unconsumed instruction.
    // Redirect suppresses the request so a stale ack cannot be captured.
    assign w_req     = !i_rst && (r_state == ST_FETCH) && !i_redirect &&
                       (!r_instr_valid || !i_stall);
    assign w_accept  = w_req && i_imem_ack;
    assign w_consume = r_instr_valid && !i_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (i_redirect) begin
            r_state       <= ST_FETCH;
            r_pc          <= i_target;
            r_instr_valid <= 1'b0;
        end else if (w_accept) begin
            r_instr       <= i_imem_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + c_inc;
            // HALT is still presented to decode; only further fetch stops.
            if (i_imem_data == HALT_WORD) begin
                r_state <= ST_HALTED;
            end
        end else if (w_consume) begin
            r_instr_valid <= 1'b0;
        end
    end

`ifdef PC_FETCH_COUNT_EN
    logic [0:WIDTH-1]   r_fetch_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_count <= '0;
        end else if (w_accept && (r_fetch_count != '1)) begin
            r_fetch_count <= r_fetch_count + WIDTH'(1);
        end
    end

    assign o_fetch_count = r_fetch_count;
`endif

    assign o_imem_req    = w_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_halted      = (r_state == ST_HALTED);

endmodule
`default_nettype wire
